// File: rtl/bt656_pkg.sv
// bt656_pkg: shared types and constants for the BT.656 receiver path.
// FSM encoding, TRS preamble words, XY field positions and protection bits.
package bt656_pkg;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] TRS_PRE_FF = 8'hFF;
    localparam logic [7:0] TRS_PRE_00 = 8'h00;

    localparam int XY_B7 = 7;
    localparam int XY_F  = 6;
    localparam int XY_V  = 5;
    localparam int XY_H  = 4;

    localparam int LINE_LEN_PAL  = 1728;
    localparam int LINE_LEN_NTSC = 1716;

    function automatic logic [3:0] xy_prot(input logic f, input logic v,
                                           input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/bt656_in_if.sv
// bt656_in_if: active-video bundle from the BT.656 receiver
// to the line buffer writer.
interface bt656_in_if;

    logic [7:0]  DATA_o;
    logic        DATA_VLD_o;
    logic        Y_FLAG_o;
    logic [10:0] PIX_CNT_o;

    modport master (
        output DATA_o,
        output DATA_VLD_o,
        output Y_FLAG_o,
        output PIX_CNT_o
    );

    modport slave (
        input DATA_o,
        input DATA_VLD_o,
        input Y_FLAG_o,
        input PIX_CNT_o
    );

endinterface

// File: rtl/bt656_xy_check.sv
// bt656_xy_check: validates the TRS XY word and returns {ok, F, V, H}.
// Build option BT656_IN_ECC_EN enables single-bit correction.
module bt656_xy_check
    import bt656_pkg::*;
(
    input  logic [7:0] i_xy,
    output logic       o_ok,
    output logic       o_f,
    output logic       o_v,
    output logic       o_h
);

    logic       w_f;
    logic       w_v;
    logic       w_h;
    logic [3:0] w_syn;

    assign w_f   = i_xy[XY_F];
    assign w_v   = i_xy[XY_V];
    assign w_h   = i_xy[XY_H];
    assign w_syn = i_xy[3:0] ^ xy_prot(w_f, w_v, w_h);

`ifdef BT656_IN_ECC_EN
    // Syndrome decode: flip the flag a single-bit error landed on,
    // ignore errors confined to a protection bit or to bit 7.
    always_comb begin
        o_ok = 1'b0;
        o_f  = w_f;
        o_v  = w_v;
        o_h  = w_h;
        if (i_xy[XY_B7]) begin
            case (w_syn)
                4'b0000, 4'b0001, 4'b0010,
                4'b0100, 4'b1000: o_ok = 1'b1;
                4'b0111: begin
                    o_ok = 1'b1;
                    o_f  = ~w_f;
                end
                4'b1011: begin
                    o_ok = 1'b1;
                    o_v  = ~w_v;
                end
                4'b1101: begin
                    o_ok = 1'b1;
                    o_h  = ~w_h;
                end
                default: o_ok = 1'b0;
            endcase
        end else begin
            o_ok = (w_syn == 4'd0);
        end
    end
`else
    assign o_ok = i_xy[XY_B7] && (w_syn == 4'd0);
    assign o_f  = w_f;
    assign o_v  = w_v;
    assign o_h  = w_h;
`endif

endmodule

// File: rtl/bt656_in.sv
// bt656_in: BT.656 8-bit receiver - TRS detect, line lock, active-video forward.
// Build option: define BT656_IN_ECC_EN to correct single-bit XY errors.
module bt656_in
    import bt656_pkg::*;
#(
    parameter int LINE_LENGTH  = LINE_LEN_PAL,
    parameter int ACTIVE_WORDS = 1440,
    parameter int LOCK_LINES   = 4
) (
    input  logic       CLK_i,
    input  logic       RST,
    input  logic       EN_i,
    input  logic [7:0] DIN_i,
    bt656_in_if.master vid,
    output logic       F_o,
    output logic       V_o,
    output logic       H_o,
    output logic [9:0] LINE_CNT_o,
    output logic       FRM_BG_o,
    output logic       LOCK_o,
    output logic       TRS_ERR_o
);

    localparam logic [10:0] LP_LEND = 11'(LINE_LENGTH - 1);
    localparam logic [10:0] LP_ALST = 11'(ACTIVE_WORDS - 1);
    localparam logic [3:0]  LP_LOCK = 4'(LOCK_LINES - 1);

    state_t      r_state;
    state_t      w_state_nx;
    logic [7:0]  r_h0;
    logic [7:0]  r_h1;
    logic [7:0]  r_h2;
    logic        w_trs;
    logic        w_xy_ok;
    logic        w_xf;
    logic        w_xv;
    logic        w_xh;
    logic        w_bad;
    logic        w_eav;
    logic        w_sav;
    logic        w_at_end;
    logic        w_miss;
    logic        w_err_fsm;
    logic        w_lock;
    logic        w_live;
    logic        w_ff;
    logic        w_fwd;
    logic        w_wff;
    logic [10:0] r_wcnt;
    logic [3:0]  r_good;
    logic        r_miss;
    logic        r_win;
    logic [10:0] r_pidx;
    logic [7:0]  r_data;
    logic        r_vld;
    logic        r_yflag;
    logic [10:0] r_pix;
    logic        r_f;
    logic        r_v;
    logic        r_h;
    logic [9:0]  r_line;
    logic        r_frm;
    logic        r_err;

    bt656_xy_check u_xy (
        .i_xy (DIN_i),
        .o_ok (w_xy_ok),
        .o_f  (w_xf),
        .o_v  (w_xv),
        .o_h  (w_xh)
    );

    assign w_trs = (r_h2 == TRS_PRE_FF) && (r_h1 == TRS_PRE_00)
                && (r_h0 == TRS_PRE_00);
    assign w_bad    = w_trs && !w_xy_ok;
    assign w_eav    = w_trs && w_xy_ok && w_xh;
    assign w_sav    = w_trs && w_xy_ok && !w_xh;
    assign w_at_end = (r_wcnt == LP_LEND);
    // A miss is a bad XY, an EAV off its slot, or an empty EAV slot.
    assign w_miss   = w_bad || (w_eav != w_at_end);
    assign w_live   = EN_i && (r_state == S_LOCKED);
    assign w_ff     = (DIN_i == TRS_PRE_FF);
    assign w_fwd    = w_live && r_win && !w_ff;
    assign w_wff    = w_live && r_win && w_ff;

    // Three-word history feeding the TRS preamble match.
    always_ff @(posedge CLK_i) begin
        if (RST) begin
            r_h0 <= 8'h00;
            r_h1 <= 8'h00;
            r_h2 <= 8'h00;
        end else begin
            r_h2 <= r_h1;
            r_h1 <= r_h0;
            r_h0 <= DIN_i;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK_i) begin
        if (RST) r_state <= S_SEARCH;
        else     r_state <= w_state_nx;
    end

    // FSM next-state: acquire on spaced EAVs, drop after two misses.
    always_comb begin
        w_state_nx = r_state;
        if (!EN_i) begin
            w_state_nx = S_SEARCH;
        end else begin
            unique case (r_state)
                S_SEARCH: if (w_eav) w_state_nx = S_TRACK;
                S_TRACK: begin
                    if (w_bad || (w_eav && !w_at_end))
                        w_state_nx = S_SEARCH;
                    else if (w_eav && r_good == LP_LOCK)
                        w_state_nx = S_LOCKED;
                end
                S_LOCKED: if (w_miss && r_miss) w_state_nx = S_SEARCH;
                default:  w_state_nx = S_SEARCH;
            endcase
        end
    end

    // FSM outputs: lock flag and timing error event.
    always_comb begin
        w_lock    = (r_state == S_LOCKED);
        w_err_fsm = 1'b0;
        if (EN_i && r_state == S_TRACK)
            w_err_fsm = w_bad || (w_eav && !w_at_end);
        else if (EN_i && r_state == S_LOCKED)
            w_err_fsm = w_miss;
    end

    // Good-EAV and consecutive-miss counters.
    always_ff @(posedge CLK_i) begin
        if (RST || w_state_nx == S_SEARCH) begin
            r_good <= 4'd0;
            r_miss <= 1'b0;
        end else begin
            if (w_eav && r_state != S_LOCKED)
                r_good <= (r_state == S_SEARCH) ? 4'd1 : r_good + 4'd1;
            if (r_state != S_LOCKED)
                r_miss <= 1'b0;
            else if (w_miss)
                r_miss <= 1'b1;
            else if (w_eav)
                r_miss <= 1'b0;
        end
    end

    // Line word counter; flywheels over a missing EAV while locked.
    always_ff @(posedge CLK_i) begin
        if (RST)
            r_wcnt <= 11'd0;
        else if (w_eav || (r_state == S_LOCKED && w_at_end))
            r_wcnt <= 11'd0;
        else if (r_wcnt != 11'h7FF)
            r_wcnt <= r_wcnt + 11'd1;
    end

    // TRS flags, line count, frame-start and error pulses.
    always_ff @(posedge CLK_i) begin
        if (RST) begin
            r_f    <= 1'b0;
            r_v    <= 1'b0;
            r_h    <= 1'b0;
            r_line <= 10'd0;
            r_frm  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_frm <= 1'b0;
            r_err <= w_err_fsm || w_wff;
            if (w_trs && w_xy_ok) begin
                r_f <= w_xf;
                r_v <= w_xv;
                r_h <= w_xh;
            end
            if (w_eav) begin
                if (r_state == S_LOCKED && r_f && !w_xf) begin
                    r_line <= 10'd0;
                    r_frm  <= 1'b1;
                end else if (r_line != 10'h3FF) begin
                    r_line <= r_line + 10'd1;
                end
            end
        end
    end

    // Active window: opened by SAV with V=0, closed by count or 0xFF.
    always_ff @(posedge CLK_i) begin
        if (RST || !w_live) begin
            r_win  <= 1'b0;
            r_pidx <= 11'd0;
        end else if (w_sav && !w_xv) begin
            r_win  <= 1'b1;
            r_pidx <= 11'd0;
        end else if (r_win) begin
            if (w_ff || r_pidx == LP_ALST) r_win <= 1'b0;
            r_pidx <= r_pidx + 11'd1;
        end
    end

    // Registered active-video output.
    always_ff @(posedge CLK_i) begin
        if (RST) begin
            r_data  <= 8'h00;
            r_vld   <= 1'b0;
            r_yflag <= 1'b0;
            r_pix   <= 11'd0;
        end else begin
            r_vld <= w_fwd;
            if (w_fwd) begin
                r_data  <= DIN_i;
                r_pix   <= r_pidx;
                r_yflag <= r_pidx[0];
            end
        end
    end

    assign vid.DATA_o     = r_data;
    assign vid.DATA_VLD_o = r_vld;
    assign vid.Y_FLAG_o   = r_yflag;
    assign vid.PIX_CNT_o  = r_pix;
    assign F_o            = r_f;
    assign V_o            = r_v;
    assign H_o            = r_h;
    assign LINE_CNT_o     = r_line;
    assign FRM_BG_o       = r_frm;
    assign LOCK_o         = w_lock;
    assign TRS_ERR_o      = r_err;

endmodule

// File: tb/tb_bt656_in.sv
// tb_bt656_in: directed PAL-stream checks of the BT.656 receiver.
// Expectations follow BT656_IN_ECC_EN when it is defined.
module tb_bt656_in;

    localparam int LL  = 1728;
    localparam int AW  = 1440;
    localparam int BLK = LL - AW - 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [7:0] din = 8'h80;
    logic       f, v, h, frm, lock, err;
    logic [9:0] lcnt;

    bt656_in_if vid ();

    bt656_in #(
        .LINE_LENGTH  (LL),
        .ACTIVE_WORDS (AW),
        .LOCK_LINES   (4)
    ) dut (
        .CLK_i      (clk),
        .RST        (rst),
        .EN_i       (en),
        .DIN_i      (din),
        .vid        (vid),
        .F_o        (f),
        .V_o        (v),
        .H_o        (h),
        .LINE_CNT_o (lcnt),
        .FRM_BG_o   (frm),
        .LOCK_o     (lock),
        .TRS_ERR_o  (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_vld, n_err, n_frm;
    int exp_lc;
    logic e_lock, e_err, e_f, e_v, e_h;
    logic [9:0] e_lcnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'h20 + 8'(k % 128);
    endfunction

    function automatic logic [7:0] lw(input int i, input logic [7:0] exy,
                                      input logic [7:0] sxy, input bit skip,
                                      input int ff_at);
        int k;
        if (i < 4) begin
            if (skip)   return 8'h80;
            if (i == 0) return 8'hFF;
            if (i < 3)  return 8'h00;
            return exy;
        end
        if (i < 4 + BLK) return i[0] ? 8'h10 : 8'h80;
        k = i - 4 - BLK;
        if (k == 0) return 8'hFF;
        if (k < 3)  return 8'h00;
        if (k == 3) return sxy;
        k = k - 4;
        return (k == ff_at) ? 8'hFF : pat(k);
    endfunction

    task automatic step(input logic [7:0] w);
        din = w;
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input logic [7:0] exy, input logic [7:0] sxy,
                             input bit skip, input int ff_at);
        n_vld = 0;
        n_err = 0;
        n_frm = 0;
        for (int i = 0; i < LL; i++) begin
            step(lw(i, exy, sxy, skip, ff_at));
            if (i == 3) begin
                e_lock = lock;
                e_err  = err;
                e_f    = f;
                e_v    = v;
                e_h    = h;
                e_lcnt = lcnt;
            end
            if (vid.DATA_VLD_o === 1'b1) begin
                chk("pix", vid.PIX_CNT_o, n_vld);
                chk("yflag", vid.Y_FLAG_o, n_vld % 2);
                chk("data", vid.DATA_o, pat(n_vld));
                n_vld++;
            end
            if (err === 1'b1) n_err++;
            if (frm === 1'b1) n_frm++;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lock"}, lock, 0);
        chk({tag, "_vld"}, vid.DATA_VLD_o, 0);
        chk({tag, "_data"}, vid.DATA_o, 0);
        chk({tag, "_yflag"}, vid.Y_FLAG_o, 0);
        chk({tag, "_pix"}, vid.PIX_CNT_o, 0);
        chk({tag, "_fvh"}, {f, v, h}, 0);
        chk({tag, "_lcnt"}, lcnt, 0);
        chk({tag, "_frm"}, frm, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        rst = 1'b1;
        step(8'h80);
        step(8'h80);
        chk_zero("rst");
        rst = 1'b0;

        for (int n = 1; n <= 4; n++) begin
            send_line(8'h9D, 8'h80, 1'b0, -1);
            chk($sformatf("acq%0d_lock", n), e_lock, n == 4);
            chk($sformatf("acq%0d_vld", n), n_vld, (n == 4) ? AW : 0);
            chk($sformatf("acq%0d_lcnt", n), e_lcnt, n);
            chk($sformatf("acq%0d_err", n), n_err, 0);
        end
        chk("acq_eav_h", e_h, 1);
        chk("acq_sav_fvh", {f, v, h}, 3'b000);

        send_line(8'h9D, 8'h80, 1'b0, -1);
        chk("l5_lcnt", e_lcnt, 5);
        chk("l5_vld", n_vld, AW);
        chk("l5_err", n_err, 0);

        send_line(8'hDD, 8'h80, 1'b0, -1);
`ifdef BT656_IN_ECC_EN
        chk("ecc_err", e_err, 0);
        chk("ecc_f", e_f, 0);
        chk("ecc_h", e_h, 1);
        chk("ecc_lcnt", e_lcnt, 6);
        exp_lc = 6;
`else
        chk("xy_err", e_err, 1);
        chk("xy_h", e_h, 0);
        chk("xy_lcnt", e_lcnt, 5);
        exp_lc = 5;
`endif
        chk("xy_lock", e_lock, 1);
        chk("xy_vld", n_vld, AW);

        send_line(8'h9D, 8'h80, 1'b0, -1);
        exp_lc++;
        chk("l7_lock", e_lock, 1);
        chk("l7_err", n_err, 0);
        chk("l7_lcnt", e_lcnt, exp_lc);

        send_line(8'h9D, 8'h80, 1'b1, -1);
        chk("miss1_err", e_err, 1);
        chk("miss1_lock", e_lock, 1);
        chk("miss1_vld", n_vld, AW);

        send_line(8'h9D, 8'h80, 1'b1, -1);
        chk("miss2_err", e_err, 1);
        chk("miss2_nerr", n_err, 1);
        chk("miss2_lock", e_lock, 0);
        chk("miss2_vld", n_vld, 0);
        chk("miss2_lcnt", e_lcnt, exp_lc);

        for (int n = 1; n <= 4; n++) begin
            send_line(8'h9D, 8'h80, 1'b0, -1);
            exp_lc++;
            chk($sformatf("rel%0d_lock", n), e_lock, n == 4);
            chk($sformatf("rel%0d_lcnt", n), e_lcnt, exp_lc);
        end

        send_line(8'hF1, 8'hEC, 1'b0, -1);
        exp_lc++;
        chk("f2_fvh", {e_f, e_v, e_h}, 3'b111);
        chk("f2_lcnt", e_lcnt, exp_lc);
        chk("f2_vld", n_vld, 0);
        chk("f2_frm", n_frm, 0);

        send_line(8'hB6, 8'hAB, 1'b0, -1);
        chk("frm_pulses", n_frm, 1);
        chk("frm_lcnt", e_lcnt, 0);
        chk("frm_f", e_f, 0);
        chk("frm_vld", n_vld, 0);
        chk("frm_lock", e_lock, 1);

        send_line(8'h9D, 8'h80, 1'b0, -1);
        chk("l16_lcnt", e_lcnt, 1);
        chk("l16_vld", n_vld, AW);
        chk("l16_frm", n_frm, 0);

        send_line(8'h9D, 8'h80, 1'b0, 700);
        chk("ff_vld", n_vld, 700);
        chk("ff_err", n_err, 1);
        chk("ff_lock", lock, 1);

        for (int i = 0; i < 4 + BLK + 4 + 100; i++)
            step(lw(i, 8'h9D, 8'h80, 1'b0, -1));
        chk("pre_rst_vld", vid.DATA_VLD_o, 1);
        chk("pre_rst_lock", lock, 1);
        rst = 1'b1;
        step(pat(100));
        chk_zero("mrst");
        rst = 1'b0;

        for (int n = 1; n <= 4; n++) begin
            send_line(8'h9D, 8'h80, 1'b0, -1);
            chk($sformatf("rl%0d_lock", n), e_lock, n == 4);
            chk($sformatf("rl%0d_lcnt", n), e_lcnt, n);
            chk($sformatf("rl%0d_vld", n), n_vld, (n == 4) ? AW : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bt656_in.md
# bt656_in

BT.656 8-bit receiver: the decode end of the team's BT.656 output path. Parses an incoming 4:2:2 word stream, detects FF 00 00 XY timing reference codes (TRS), recovers F/V/H, locks to line timing and forwards active-video words with component tags, field/frame flags and line/word counts. Sits between the camera/decoder pad interface and the line buffer writer.

## Interface
- LINE_LENGTH, 1728: words per line including TRS and blanking (1716 for NTSC).
- ACTIVE_WORDS, 1440: active words following each SAV.
- LOCK_LINES, 4: consecutive correctly spaced EAVs needed to lock.
- CLK_i  input  1  word clock; all logic on rising edge.
- RST  input  1  reset; synchronous, active-high.
- EN_i  input  1  receiver enable; low holds the FSM in S_SEARCH.
- DIN_i  input  8  BT.656 word stream.
- DATA_o  output  8  active-video word.
- DATA_VLD_o  output  1  DATA_o valid.
- Y_FLAG_o  output  1  DATA_o is luma (Cb/Cr when low).
- F_o, V_o, H_o  output  1 each  last accepted TRS flags.
- LINE_CNT_o  output  10  line within frame, 0 at frame start.
- PIX_CNT_o  output  11  active word index 0..ACTIVE_WORDS-1.
- FRM_BG_o  output  1  one-cycle frame-start pulse.
- LOCK_o  output  1  high in S_LOCKED.
- TRS_ERR_o  output  1  one-cycle error pulse.

## Operation
- 3-word history of DIN_i; TRS detected when history = FF,00,00 and current word is XY. XY = {1,F,V,H,V^H,F^H,F^V,F^V^H}; H=1 EAV, H=0 SAV.
- XY check: bit7 = 1 and syndrome (received P3..P0 xor recomputed) = 0 → accepted; otherwise uncorrectable (see Configuration).
- Line word counter: restarts at 0 on the XY of every accepted EAV, increments each cycle.
- FSM:
  - S_SEARCH: accepted EAV → S_TRACK, good-count = 1.
  - S_TRACK: accepted EAV with counter = LINE_LENGTH-1 → good-count+1; reaching LOCK_LINES → S_LOCKED. Misplaced EAV or uncorrectable XY → S_SEARCH, TRS_ERR_o.
  - S_LOCKED: misplaced/missing EAV (counter reaching LINE_LENGTH without EAV) or uncorrectable XY → miss-count+1, TRS_ERR_o; 2 consecutive misses → S_SEARCH; a good EAV clears miss-count.
  - EN_i low or RST → S_SEARCH from any state.
- Active window (S_LOCKED only): accepted SAV with V=0 opens it; next ACTIVE_WORDS words forwarded. Word 0 Cb, 1 Y, 2 Cr, 3 Y…; Y_FLAG_o = PIX_CNT_o[0].
- An input word 0xFF inside the window closes it, is not forwarded, and pulses TRS_ERR_o (short line).
- F_o/V_o/H_o update on every accepted TRS. LINE_CNT_o increments on each accepted EAV, saturates at 1023; on an accepted EAV where F goes 1→0 while locked, LINE_CNT_o ← 0 and FRM_BG_o pulses.
- Reset values: all outputs 0, FSM S_SEARCH, counters 0, history cleared.

## Timing
- DATA_o/DATA_VLD_o/Y_FLAG_o/PIX_CNT_o registered: word sampled at edge n appears at edge n+1 (latency 1).
- F_o/V_o/H_o, LOCK_o, FRM_BG_o, TRS_ERR_o, LINE_CNT_o update one cycle after the XY word is sampled.
- First active word: XY of SAV at edge n → first DATA_VLD_o at edge n+2.
- Overlapping FF 00 00 patterns: detection purely on the current 4-word window; data 0xFF outside a window is just history.
- TRS during open window: window closes; TRS is processed normally.

## Configuration
- BT656_IN_ECC_EN defined: single-bit XY errors corrected; syndrome 0111→invert F, 1011→invert V, 1101→invert H, single-bit syndrome or bit7=0 with syndrome 0 → parity/bit7 error ignored; other syndromes uncorrectable. Corrected codes are accepted without TRS_ERR_o.
- Undefined: any bit7 or syndrome mismatch is uncorrectable.

## Structure
- Shared package bt656_pkg: FSM state encoding, TRS preamble constants (8'hFF, 8'h00), XY field positions, protection-bit function, PAL/NTSC line length constants.
- Sub-module bt656_xy_check: combinational XY validate/correct → {ok, F, V, H}; ECC macro confined to it.

## Test plan
- Clean PAL stream, LINE_LENGTH 1728 → LOCK_o rises on 4th EAV XY +1 cycle; 1440 DATA_VLD_o per active line, Y_FLAG_o 0,1,0,1.
- XY 0x9D with F flipped (0x9D→0xDD) → with macro accepted, F_o=0, no TRS_ERR_o; without macro TRS_ERR_o pulses, miss-count 1.
- Two consecutive missing EAVs while locked → two TRS_ERR_o pulses, LOCK_o falls after second.
- Field 2→field 1 transition (XY 0xF1 then 0xB6) → FRM_BG_o one pulse, LINE_CNT_o = 0.
- 0xFF injected at active word 700 → DATA_VLD_o drops, 700 words delivered, TRS_ERR_o pulse.
- RST mid-line → next edge all outputs 0, LOCK_o 0, relock needs 4 EAVs.
